// File: rtl/multdiv_seq.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring, on magnitudes) that borrows an external ALU.
// Latency: multiply 33 cycles, divide 36, divide-by-zero 1; data_resultRDY pulses once per completed operation.
// No backpressure: starts outside IDLE/DONE are dropped unless MULTDIV_RESTART_EN lets them abort the current op.
module multdiv_seq #(
    parameter logic [4:0] OP_ADD = 5'b00000,
    parameter logic [4:0] OP_SUB = 5'b00001
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic [31:0] alu_operandA,
    output logic [31:0] alu_operandB,
    output logic [4:0]  alu_opcode,
    input  logic [31:0] alu_result,
    input  logic        alu_overflow,
    input  logic        alu_isLessThan
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MUL   = 3'd1,
        S_ABS_A = 3'd2,
        S_ABS_B = 3'd3,
        S_DIV   = 3'd4,
        S_SIGN  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t      state, state_nxt;
    logic [4:0]  cnt;
    // acc is the Booth high word or the partial remainder; shreg is the Booth low word or the quotient;
    // opnd is the multiplicand or the divisor.
    logic [31:0] acc;
    logic [31:0] shreg;
    logic [31:0] opnd;
    logic        qbit;
    logic        neg;

    logic        start_ok;
    logic        do_mul;
    logic        do_div;
    logic        div_zero;
    logic        last_iter;
    logic [1:0]  booth;
    logic        mul_t;
    logic [31:0] mul_hi_nxt;
    logic [31:0] mul_lo_nxt;
    logic [31:0] div_rs;
    logic        div_ge;

`ifdef MULTDIV_RESTART_EN
    assign start_ok = 1'b1;
`else
    assign start_ok = (state == S_IDLE) || (state == S_DONE);
`endif

    assign do_mul    = start_ok & ctrl_MULT;
    assign do_div    = start_ok & ~ctrl_MULT & ctrl_DIV;
    assign div_zero  = (data_operandB == 32'd0);
    assign last_iter = (cnt == 5'd31);

    assign booth      = {shreg[0], qbit};
    // The ALU sum may overflow by one bit; the corrected sign keeps the arithmetic shift exact.
    assign mul_t      = alu_result[31] ^ alu_overflow;
    assign mul_hi_nxt = {mul_t, alu_result[31:1]};
    assign mul_lo_nxt = {alu_result[0], shreg[31:1]};

    // Unsigned Rs >= D built from the ALU's signed compare plus the operand MSBs.
    assign div_rs = {acc[30:0], shreg[31]};
    assign div_ge = acc[31]
                  | (div_rs[31] & ~opnd[31])
                  | (~(div_rs[31] ^ opnd[31]) & ~alu_isLessThan);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (do_mul) begin
            state_nxt = S_MUL;
        end else if (do_div) begin
            state_nxt = div_zero ? S_DONE : S_ABS_A;
        end else begin
            case (state)
                S_IDLE:  state_nxt = S_IDLE;
                S_MUL:   state_nxt = last_iter ? S_DONE : S_MUL;
                S_ABS_A: state_nxt = S_ABS_B;
                S_ABS_B: state_nxt = S_DIV;
                S_DIV:   state_nxt = last_iter ? S_SIGN : S_DIV;
                S_SIGN:  state_nxt = S_DONE;
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        alu_opcode     = OP_ADD;
        alu_operandA   = 32'd0;
        alu_operandB   = 32'd0;
        data_resultRDY = (state == S_DONE);
        case (state)
            S_MUL: begin
                alu_operandA = acc;
                case (booth)
                    2'b01: alu_operandB = opnd;
                    2'b10: begin
                        alu_opcode   = OP_SUB;
                        alu_operandB = opnd;
                    end
                    default: alu_operandB = 32'd0;
                endcase
            end
            S_ABS_A: begin
                alu_opcode   = OP_SUB;
                alu_operandB = shreg;
            end
            S_ABS_B: begin
                alu_opcode   = OP_SUB;
                alu_operandB = opnd;
            end
            S_DIV: begin
                alu_opcode   = OP_SUB;
                alu_operandA = div_rs;
                alu_operandB = opnd;
            end
            S_SIGN: begin
                alu_opcode   = OP_SUB;
                alu_operandB = shreg;
            end
            default: begin
                alu_opcode   = OP_ADD;
                alu_operandA = 32'd0;
                alu_operandB = 32'd0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt            <= 5'd0;
            acc            <= 32'd0;
            shreg          <= 32'd0;
            opnd           <= 32'd0;
            qbit           <= 1'b0;
            neg            <= 1'b0;
            data_result    <= 32'd0;
            data_exception <= 1'b0;
        end else if (do_mul) begin
            opnd  <= data_operandA;
            acc   <= 32'd0;
            shreg <= data_operandB;
            qbit  <= 1'b0;
            cnt   <= 5'd0;
        end else if (do_div) begin
            if (div_zero) begin
                data_result    <= 32'd0;
                data_exception <= 1'b1;
            end else begin
                shreg <= data_operandA;
                opnd  <= data_operandB;
                neg   <= data_operandA[31] ^ data_operandB[31];
            end
        end else begin
            case (state)
                S_MUL: begin
                    acc   <= mul_hi_nxt;
                    shreg <= mul_lo_nxt;
                    qbit  <= shreg[0];
                    cnt   <= cnt + 5'd1;
                    if (last_iter) begin
                        data_result    <= mul_lo_nxt;
                        data_exception <= (mul_hi_nxt != {32{mul_lo_nxt[31]}});
                    end
                end
                S_ABS_A: begin
                    if (shreg[31]) begin
                        shreg <= alu_result;
                    end
                end
                S_ABS_B: begin
                    if (opnd[31]) begin
                        opnd <= alu_result;
                    end
                    acc <= 32'd0;
                    cnt <= 5'd0;
                end
                S_DIV: begin
                    acc   <= div_ge ? alu_result : div_rs;
                    shreg <= {shreg[30:0], div_ge};
                    cnt   <= cnt + 5'd1;
                end
                S_SIGN: begin
                    // A positive quotient with bit 31 set can only come from -2^31 / -1.
                    if (~neg & shreg[31]) begin
                        data_result    <= 32'd0;
                        data_exception <= 1'b1;
                    end else begin
                        data_result    <= neg ? alu_result : shreg;
                        data_exception <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_seq.sv
// Randomised and directed bench for multdiv_seq with a combinational ALU and an arithmetic reference model.
`timescale 1ns/1ps
module tb_multdiv_seq;

    logic        clock = 1'b0;
    logic        reset;
    logic        ctrl_MULT, ctrl_DIV;
    logic [31:0] data_operandA, data_operandB;
    logic [31:0] data_result;
    logic        data_exception, data_resultRDY;
    logic [31:0] alu_operandA, alu_operandB, alu_result;
    logic [4:0]  alu_opcode;
    logic        alu_overflow, alu_isLessThan;

`ifdef MULTDIV_RESTART_EN
    localparam bit RESTART = 1'b1;
`else
    localparam bit RESTART = 1'b0;
`endif

    always #5 clock = ~clock;

    multdiv_seq dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .alu_operandA   (alu_operandA),
        .alu_operandB   (alu_operandB),
        .alu_opcode     (alu_opcode),
        .alu_result     (alu_result),
        .alu_overflow   (alu_overflow),
        .alu_isLessThan (alu_isLessThan)
    );

    // External ALU: add / subtract with signed overflow and signed less-than.
    assign alu_result = (alu_opcode == 5'b00000) ? alu_operandA + alu_operandB :
                        (alu_opcode == 5'b00001) ? alu_operandA - alu_operandB : 32'd0;
    assign alu_overflow = (alu_opcode == 5'b00000) ?
                              ((alu_operandA[31] == alu_operandB[31]) && (alu_result[31] != alu_operandA[31])) :
                          (alu_opcode == 5'b00001) ?
                              ((alu_operandA[31] != alu_operandB[31]) && (alu_result[31] != alu_operandA[31])) : 1'b0;
    assign alu_isLessThan = ($signed(alu_operandA) < $signed(alu_operandB));

    typedef struct {
        int          due;
        logic [31:0] res;
        logic        exc;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          issue_cyc = 0;
    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] held_res = 32'd0;
    logic        held_exc = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model(input logic mul, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic e, output int lat);
        logic signed [63:0] p;
        if (mul) begin
            p   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            r   = p[31:0];
            e   = (p[63:32] != {32{p[31]}});
            lat = 33;
        end else if (b == 32'd0) begin
            r = 32'd0; e = 1'b1; lat = 1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = 32'd0; e = 1'b1; lat = 36;
        end else begin
            r = 32'($signed(a) / $signed(b));
            e = 1'b0; lat = 36;
        end
    endfunction

    // Every cycle: ready pulse exactly when due; otherwise outputs hold the last completed result.
    always @(negedge clock) begin
        logic hit;
        hit = 1'b0;
        if (q.size() != 0) hit = (q[0].due == cyc);
        if (hit) begin
            chk("rdy", 32'(data_resultRDY), 32'd1);
            chk("result", data_result, q[0].res);
            chk("exception", 32'(data_exception), 32'(q[0].exc));
            held_res = q[0].res;
            held_exc = q[0].exc;
            void'(q.pop_front());
        end else begin
            chk("rdy_quiet", 32'(data_resultRDY), 32'd0);
            chk("held_result", data_result, held_res);
            chk("held_exception", 32'(data_exception), 32'(held_exc));
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic busy;
        int   lat;
        ctrl_MULT = m; ctrl_DIV = d; data_operandA = a; data_operandB = b;
        busy = 1'b0;
        if (q.size() != 0) busy = (q[$].due > cyc);
        if ((m || d) && (!busy || RESTART)) begin
            while (q.size() != 0 && q[$].due > cyc) void'(q.pop_back());
            model(m, a, b, e.res, e.exc, lat);
            e.due = cyc + lat;
            q.push_back(e);
            issue_cyc = cyc;
        end
        step();
        ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            step();
            n++;
        end
        chk("drain_timeout", 32'(q.size()), 32'd0);
        q.delete();
    endtask

    task automatic expect_done(input string name, input logic [31:0] res, input logic exc, input int lat);
        int n = 0;
        while (!data_resultRDY && n < 100) begin
            step();
            n++;
        end
        chk({name, "_latency"}, 32'(cyc - issue_cyc), 32'(lat));
        chk({name, "_result"}, data_result, res);
        chk({name, "_exception"}, 32'(data_exception), 32'(exc));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: pick = 32'd0;
            1: pick = 32'h8000_0000;
            2: pick = 32'hFFFF_FFFF;
            3: pick = 32'd1;
            4: pick = 32'($urandom_range(0, 15));
            5: pick = -32'($urandom_range(1, 15));
            default: pick = $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] bm;
        logic        prev;
        logic [1:0]  pair;
        reset = 1'b1; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
        data_operandA = 32'd0; data_operandB = 32'd0;
        #12;
        chk("reset_result", data_result, 32'd0);
        chk("reset_exception", 32'(data_exception), 32'd0);
        chk("reset_rdy", 32'(data_resultRDY), 32'd0);
        step();
        reset = 1'b0;
        step(); step();

        // 7 * -6 with the Booth opcode sequence read off the multiplier bits.
        bm = 32'hFFFF_FFFA;
        issue(1'b1, 1'b0, 32'd7, bm);
        prev = 1'b0;
        for (int i = 0; i < 32; i++) begin
            pair = {bm[i], prev};
            chk("booth_opcode", 32'(alu_opcode), (pair == 2'b10) ? 32'd1 : 32'd0);
            chk("booth_operandB", alu_operandB, (pair == 2'b01 || pair == 2'b10) ? 32'd7 : 32'd0);
            prev = bm[i];
            step();
        end
        expect_done("mul_7_m6", 32'hFFFF_FFD6, 1'b0, 33);
        wait_idle();

        issue(1'b1, 1'b0, 32'h8000_0000, 32'd1);
        expect_done("mul_min_1", 32'h8000_0000, 1'b0, 33);
        wait_idle();
        issue(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
        expect_done("mul_ovf", 32'd0, 1'b1, 33);
        wait_idle();

        issue(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
        expect_done("div_m7_2", 32'hFFFF_FFFD, 1'b0, 36);
        wait_idle();
        issue(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h8000_0000);
        expect_done("div_m1_min", 32'd0, 1'b0, 36);
        wait_idle();

        issue(1'b0, 1'b1, 32'd5, 32'd0);
        expect_done("div_by_zero", 32'd0, 1'b1, 1);
        wait_idle();
        issue(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        expect_done("div_min_m1", 32'd0, 1'b1, 36);
        wait_idle();

        // Divide request at cycle 10 of a multiply.
        issue(1'b1, 1'b0, 32'd1234, 32'd5);
        repeat (9) step();
        issue(1'b0, 1'b1, 32'd100, 32'd7);
`ifdef MULTDIV_RESTART_EN
        expect_done("restart_div", 32'd14, 1'b0, 36);
`else
        expect_done("busy_ignored", 32'd6170, 1'b0, 33);
`endif
        wait_idle();

        // Reset in the middle of a divide.
        issue(1'b0, 1'b1, 32'd1000, 32'd3);
        repeat (10) step();
        reset = 1'b1;
        q.delete();
        held_res = 32'd0;
        held_exc = 1'b0;
        #1;
        chk("midreset_result", data_result, 32'd0);
        chk("midreset_exception", 32'(data_exception), 32'd0);
        chk("midreset_rdy", 32'(data_resultRDY), 32'd0);
        step(); step();
        reset = 1'b0;
        step();
        issue(1'b1, 1'b0, 32'd3, 32'd4);
        expect_done("mul_3_4", 32'd12, 1'b0, 33);
        wait_idle();

        for (int k = 0; k < 60; k++) begin
            int          mode;
            int          n;
            logic        m;
            mode = $urandom_range(0, 9);
            m    = ($urandom_range(0, 1) == 1);
            issue(m || (mode == 0), !m || (mode == 0), pick(), pick());
            if (mode == 1) begin
                repeat ($urandom_range(1, 30)) step();
                m = ($urandom_range(0, 1) == 1);
                issue(m, !m, pick(), pick());
            end else if (mode == 2) begin
                n = 0;
                while (q.size() != 0 && q[$].due > cyc && n < 60) begin
                    step();
                    n++;
                end
                m = ($urandom_range(0, 1) == 1);
                issue(m, !m, pick(), pick());
            end
            wait_idle();
            repeat ($urandom_range(0, 2)) step();
        end

        repeat (3) step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", n_vec, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/multdiv_seq.md
Name: multdiv_seq

Overview:
- Iterative signed multiply/divide sequencer for the processor's execute stage.
- Does not contain its own adder. Every add, subtract and negate is issued to one external 32-bit ALU through the alu_* ports, and the block consumes that ALU's result, overflow and isLessThan.
- Multiply uses radix-2 Booth over 32 iterations. Divide uses restoring division on magnitudes over 32 iterations.
- Outputs a 32-bit result, an exception flag and a one-cycle ready pulse.

Parameters:
- OP_ADD, 5'b00000, ALU opcode for add.
- OP_SUB, 5'b00001, ALU opcode for subtract.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- ctrl_MULT  in  1  start-multiply pulse; operands sampled on the same edge.
- ctrl_DIV  in  1  start-divide pulse; operands sampled on the same edge.
- data_operandA  in  32  multiplicand / dividend, signed.
- data_operandB  in  32  multiplier / divisor, signed.
- data_result  out  32  product low word or quotient; held until next start.
- data_exception  out  1  overflow or divide error; valid with data_resultRDY, held with data_result.
- data_resultRDY  out  1  one-cycle completion pulse.
- alu_operandA  out  32  ALU operand A.
- alu_operandB  out  32  ALU operand B.
- alu_opcode  out  5  ALU opcode.
- alu_result  in  32  ALU result, same cycle (ALU is combinational).
- alu_overflow  in  1  ALU signed overflow.
- alu_isLessThan  in  1  ALU signed A<B, computed from A-B.

Behaviour:
- Reset (async, any state): state=IDLE; counter=0; data_result=0; data_exception=0; data_resultRDY=0; all internal registers 0.
- Default ALU drive (IDLE, DONE): opcode=OP_ADD, operands 0.
- States: IDLE, MUL, ABS_A, ABS_B, DIV, SIGN, DONE.
- Start rules:
  - A start is accepted only in IDLE or DONE.
  - If ctrl_MULT and ctrl_DIV are both high, multiply wins.
  - Starts arriving in any other state are ignored.
- Multiply setup (start edge): M=A, hi=0, lo=B, q=0, cnt=0, next state MUL.
- MUL, one iteration per cycle, 32 cycles:
  - ALU operation selected by {lo[0],q}:
    - 01: hi+M (OP_ADD).
    - 10: hi-M (OP_SUB).
    - 00 or 11: hi+0 (OP_ADD).
  - With s=alu_result, true sign t = s[31]^alu_overflow.
  - Register update: hi<={t,s[31:1]}; lo<={s[0],lo[31:1]}; q<=lo[0].
  - After cnt==31: go to DONE.
  - data_result<=final lo.
  - data_exception<=(final hi != {32{final lo[31]}}).
- Divide setup (start edge):
  - If B==0: data_result<=0, data_exception<=1, go directly to DONE. data_resultRDY is high the next cycle.
  - Otherwise: latch A, B and neg=A[31]^B[31]; go to ABS_A.
- ABS_A: ALU 0-A (OP_SUB); Q<= A[31] ? alu_result : A.
- ABS_B: ALU 0-B (OP_SUB); D<= B[31] ? alu_result : B; R=0; cnt=0.
  - Magnitudes are unsigned; 0x80000000 stays 0x80000000.
- DIV, 32 cycles:
  - r32=R[31]; Rs={R[30:0],Q[31]}; ALU computes Rs-D (OP_SUB).
  - ge = r32 | (Rs[31]&~D[31]) | ((Rs[31]~^D[31]) & ~alu_isLessThan).
  - If ge: R<=alu_result, Q<={Q[30:0],1}. Else: R<=Rs, Q<={Q[30:0],0}.
  - After cnt==31: go to SIGN.
- SIGN: ALU 0-Q (OP_SUB).
  - data_result<= neg ? alu_result : Q.
  - data_exception<= ~neg & Q[31]. This is the -2^31/-1 case; data_result is forced to 0 when it fires.
  - Go to DONE.
  - Quotient truncates toward zero; the remainder is discarded.
- DONE: data_resultRDY=1 for exactly this cycle, then IDLE.
  - A start in DONE is accepted; data_resultRDY still pulses that cycle.
- Latency, counted from the edge that samples the start (edge 0):
  - Multiply: data_resultRDY high during cycle 33.
  - Divide: cycle 36.
  - Divide by zero: cycle 1.
- data_result and data_exception remain stable from DONE until the next accepted start's result is written.

Optional Feature:
- Macro: MULTDIV_RESTART_EN.
- When defined: a start pulse in any busy state (MUL, ABS_A, ABS_B, DIV, SIGN) aborts the current operation. The new operation is set up on that edge with full latency from that edge; no data_resultRDY is produced for the aborted operation.
- When undefined: starts in busy states are ignored, as described in Behaviour.

Test Plan:
- ctrl_MULT, A=7, B=-6 -> data_resultRDY at cycle 33, result 0xFFFFFFD6, exception 0. The ALU opcode sequence must match the Booth pairs.
- ctrl_MULT, A=0x80000000, B=1 -> result 0x80000000, exception 0 (Booth overflow-corrected sign). Then A=0x00010000, B=0x00010000 -> result 0, exception 1.
- ctrl_DIV, A=-7, B=2 -> data_resultRDY at cycle 36, result 0xFFFFFFFD, exception 0. Then A=0xFFFFFFFF (unsigned magnitude check: -1), B=0x80000000 -> result 0.
- ctrl_DIV, A=5, B=0 -> data_resultRDY at cycle 1, result 0, exception 1. Then A=0x80000000, B=0xFFFFFFFF -> result 0, exception 1.
- ctrl_DIV at cycle 10 of an in-flight multiply -> ignored; the multiply completes at cycle 33. With MULTDIV_RESTART_EN defined -> the divide completes 36 cycles after its own start and the multiply produces no ready pulse.
- reset asserted mid-DIV -> all outputs 0 immediately. After release, a new ctrl_MULT with 3*4 returns 12 at cycle 33.
